// File: rtl/sync_fifo_mode.sv
// Single-clock circular-buffer FIFO with any DEPTH, optional first-word-fall-through,
// drop-new or overwrite-oldest overflow handling, almost flags, flush and drop counter.
// Latency: 1 cycle write-to-visible; FWFT=0 read data 1 cycle after pop edge.
// Backpressure: full refuses pushes (drop-new) or evicts the oldest entry (overwrite-oldest).
module sync_fifo_mode #(
  parameter int W          = 72,
  parameter int DEPTH      = 4,
  parameter int FWFT       = 0,
  parameter int OVF_POLICY = 0,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 pop_data,
  output logic                         pop_valid,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_empty,
  output logic                         almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow,
  output logic [CNT_W-1:0]             drop_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);

  // Reject configurations the flag and pointer logic cannot represent.
  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_mode: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_mode: AF_THRESH must be within 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_mode: AE_THRESH must be within 0..DEPTH-1");
  end

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          pop_acc, push_acc, overwrite, rd_adv, ovf_evt, unf_evt;
  logic [CW-1:0] cnt_n;

  // Explicit compare-and-wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Accept decisions and next occupancy for the current edge.
  always_comb begin
    pop_acc   = pop && !empty;
    push_acc  = push && (!full || pop_acc || (OVF_POLICY == 1));
    overwrite = push_acc && full && !pop_acc;
    rd_adv    = pop_acc || overwrite;
    ovf_evt   = push && full && !pop_acc;
    unf_evt   = pop && empty;
    cnt_n     = count;
    if (push_acc && !rd_adv) begin
      cnt_n = count + CW'(1);
    end else if (rd_adv && !push_acc) begin
      cnt_n = count - CW'(1);
    end
  end

  // Pointers, occupancy, registered flags, event pulses and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      drop_count   <= '0;
    end else if (flush) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (rd_adv)   rd_ptr <= ptr_inc(rd_ptr);
      if (push_acc) wr_ptr <= ptr_inc(wr_ptr);
      count        <= cnt_n;
      empty        <= (cnt_n == '0);
      full         <= (cnt_n == DEPTH_C);
      almost_empty <= (cnt_n <= AE_C);
      almost_full  <= (cnt_n >= AF_C);
      overflow     <= ovf_evt;
      underflow    <= unf_evt;
      if (ovf_evt && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

  // Storage write; when full in overwrite mode wr_ptr equals rd_ptr, replacing the oldest word.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_acc) begin
      mem[wr_ptr] <= push_data;
    end
  end

  if (FWFT == 0) begin : g_registered_read
    // Registered read: head word captured on the accepted pop edge, qualified for one cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        pop_data  <= '0;
        pop_valid <= 1'b0;
      end else if (flush) begin
        pop_valid <= 1'b0;
      end else begin
        pop_valid <= pop_acc;
        if (pop_acc) begin
          pop_data <= mem[rd_ptr];
        end
      end
    end
  end else begin : g_fwft_read
    // Fall-through read: head word shown directly from storage, zero when nothing is held.
    assign pop_data  = empty ? '0 : mem[rd_ptr];
    assign pop_valid = !empty;
  end

endmodule

// File: tb/tb_sync_fifo_mode.sv
// Three sync_fifo_mode configurations driven by shared stimulus, each checked
// against a queue-based reference model after every clock edge.
module tb_sync_fifo_mode;

  logic        clk = 1'b0;
  logic        rst, flush, push, pop;
  logic [15:0] push_data;

  logic [15:0] pd   [3];
  logic        pv   [3];
  logic        emp  [3];
  logic        ful  [3];
  logic        aem  [3];
  logic        afl  [3];
  logic [2:0]  cnt  [3];
  logic        ovf  [3];
  logic        unf  [3];
  logic [15:0] dc   [3];
  logic [15:0] dc0;
  logic [2:0]  dc1;
  logic [7:0]  dc2;

  assign dc[0] = dc0;
  assign dc[1] = {13'b0, dc1};
  assign dc[2] = {8'b0, dc2};

  always #5 clk = ~clk;

  sync_fifo_mode #(.W(16), .DEPTH(5), .FWFT(0), .OVF_POLICY(0), .AF_THRESH(4), .AE_THRESH(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pd[0]), .pop_valid(pv[0]), .empty(emp[0]), .full(ful[0]), .almost_empty(aem[0]),
    .almost_full(afl[0]), .count(cnt[0]), .overflow(ovf[0]), .underflow(unf[0]), .drop_count(dc0));

  sync_fifo_mode #(.W(16), .DEPTH(4), .FWFT(0), .OVF_POLICY(1), .AF_THRESH(3), .AE_THRESH(1), .CNT_W(3)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pd[1]), .pop_valid(pv[1]), .empty(emp[1]), .full(ful[1]), .almost_empty(aem[1]),
    .almost_full(afl[1]), .count(cnt[1]), .overflow(ovf[1]), .underflow(unf[1]), .drop_count(dc1));

  sync_fifo_mode #(.W(16), .DEPTH(4), .FWFT(1), .OVF_POLICY(0), .AF_THRESH(3), .AE_THRESH(1), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pd[2]), .pop_valid(pv[2]), .empty(emp[2]), .full(ful[2]), .almost_empty(aem[2]),
    .almost_full(afl[2]), .count(cnt[2]), .overflow(ovf[2]), .underflow(unf[2]), .drop_count(dc2));

  // Configuration of each instance as seen by the model.
  int          m_depth [3] = '{5, 4, 4};
  int          m_fwft  [3] = '{0, 0, 1};
  int          m_ovw   [3] = '{0, 1, 0};
  int          m_af    [3] = '{4, 3, 3};
  int          m_ae    [3] = '{1, 1, 1};
  int          m_cmax  [3] = '{65535, 7, 255};

  // Model state: contents as a queue, plus the last observable read/event results.
  logic [15:0] mq      [3][$];
  int          m_drop  [3];
  logic [15:0] m_pd    [3];
  logic        m_pv    [3];
  logic        m_ovf   [3];
  logic        m_unf   [3];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int i);
    logic [15:0] v;
    if (rst) begin
      mq[i].delete();
      m_drop[i] = 0; m_pd[i] = '0; m_pv[i] = 1'b0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
    end else if (flush) begin
      mq[i].delete();
      m_pv[i] = 1'b0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
    end else begin
      m_unf[i] = pop && (mq[i].size() == 0);
      m_ovf[i] = 1'b0;
      m_pv[i]  = 1'b0;
      if (pop && mq[i].size() > 0) begin
        v = mq[i].pop_front();
        m_pd[i] = v;
        m_pv[i] = 1'b1;
      end
      if (push) begin
        if (mq[i].size() < m_depth[i]) begin
          mq[i].push_back(push_data);
        end else begin
          m_ovf[i] = 1'b1;
          if (m_drop[i] < m_cmax[i]) m_drop[i]++;
          if (m_ovw[i] == 1) begin
            v = mq[i].pop_front();
            mq[i].push_back(push_data);
          end
        end
      end
    end
  endtask

  task automatic check_inst(input int i);
    int          n;
    logic [15:0] epd;
    logic        epv;
    n = mq[i].size();
    if (m_fwft[i] == 1) begin
      epd = (n > 0) ? mq[i][0] : 16'h0;
      epv = (n > 0);
    end else begin
      epd = m_pd[i];
      epv = m_pv[i];
    end
    check($sformatf("u%0d.count", i), 32'(cnt[i]), 32'(n));
    check($sformatf("u%0d.empty_full", i), {30'b0, emp[i], ful[i]}, {30'b0, n == 0, n == m_depth[i]});
    check($sformatf("u%0d.almost", i), {30'b0, aem[i], afl[i]}, {30'b0, n <= m_ae[i], n >= m_af[i]});
    check($sformatf("u%0d.pop_data", i), 32'(pd[i]), 32'(epd));
    check($sformatf("u%0d.pop_valid", i), 32'(pv[i]), 32'(epv));
    check($sformatf("u%0d.ovf_unf", i), {30'b0, ovf[i], unf[i]}, {30'b0, m_ovf[i], m_unf[i]});
    check($sformatf("u%0d.drop_count", i), 32'(dc[i]), 32'(m_drop[i]));
  endtask

  task automatic cyc(input logic r, input logic f, input logic pu, input logic po, input logic [15:0] d);
    rst = r; flush = f; push = pu; pop = po; push_data = d;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    for (int i = 0; i < 3; i++) check_inst(i);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;

    // Reset state.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 16'h1234);

    // Fill past capacity, drain, then pop on empty.
    for (int v = 1; v <= 6; v++) cyc(0, 0, 1, 0, 16'(v));
    check("p1.drop_after_6", 32'(dc[0]), 32'd1);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1, 0);
    check("p1.pop_data_held", 32'(pd[0]), 32'd5);
    check("p1.underflow", 32'(unf[0]), 32'd1);

    // Pointer wrap with occupancy held at 3.
    cyc(1, 0, 0, 0, 0);
    for (int v = 16'h10; v <= 16'h12; v++) cyc(0, 0, 1, 0, 16'(v));
    for (int v = 16'h13; v <= 16'h1C; v++) cyc(0, 0, 1, 1, 16'(v));
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 0);

    // Overwrite-oldest: push 1..6 into depth 4, then drain.
    cyc(1, 0, 0, 0, 0);
    for (int v = 1; v <= 6; v++) cyc(0, 0, 1, 0, 16'(v));
    check("p3.drop", 32'(dc[1]), 32'd2);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 0);
    check("p3.last_word", 32'(pd[1]), 32'd6);

    // Fall-through visibility, then push+pop on full; also steps count up and down.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 16'h00AA);
    check("p4.fwft_data", 32'(pd[2]), 32'h00AA);
    check("p4.fwft_valid", 32'(pv[2]), 32'd1);
    for (int v = 2; v <= 4; v++) cyc(0, 0, 1, 0, 16'(v));
    cyc(0, 0, 1, 1, 16'h0055);
    check("p4.full_pushpop_cnt", 32'(cnt[2]), 32'd4);
    check("p4.full_pushpop_ovf", 32'(ovf[2]), 32'd0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1, 0);

    // Push and pop on empty: pop refused, push taken.
    cyc(0, 0, 1, 1, 16'h0077);

    // Flush with a push in the same cycle, then reset.
    cyc(1, 0, 0, 0, 0);
    for (int v = 1; v <= 3; v++) cyc(0, 0, 1, 0, 16'(v + 16'h20));
    cyc(0, 1, 1, 0, 16'h0099);
    check("p6.flush_count", 32'(cnt[0]), 32'd0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);

    // Drop counter saturation on the narrow counter.
    for (int v = 0; v < 14; v++) cyc(0, 0, 1, 0, 16'(v + 16'h40));
    check("sat.drop", 32'(dc[1]), 32'd7);

    // Randomized traffic, alternating fill-biased and drain-biased phases.
    for (int k = 0; k < 1200; k++) begin
      logic r, f, pu, po;
      int   bias;
      bias = ((k / 60) % 2 == 0) ? 75 : 30;
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 59) == 0);
      pu = ($urandom_range(0, 99) < bias);
      po = ($urandom_range(0, 99) < (105 - bias));
      cyc(r, f, pu, po, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
